mul_unit: RTL and testbench

Iterative 32x32 multiplier for the miniRISC datapath. It sits directly upstream of the HI and LO result registers. It takes two operands from the register-file read ports and computes the 64-bit product with one shift-add step per cycle. It then presents the result on `hi`/`lo` together with a one-cycle `done` strobe that drives the write-enable of both result registers.

---
 rtl/mul_unit.sv | 114 +++++++++++
 tb/tb_mul_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mul_unit: iterative shift-add WIDTHxWIDTH multiplier feeding HI/LO.   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module mul_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplr_q, mplr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic [WIDTH:0]       w_sum;
   logic [2*WIDTH-1:0]   w_prod;

   // Extra top bit keeps the carry of the partial-product add.
   assign w_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (mplr_q[0] ? mcand_q : {WIDTH{1'b0}})};
   assign w_prod = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               mcand_d = (is_signed & a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
               mplr_d  = (is_signed & b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d  = (2*WIDTH)'({w_sum, acc_q[WIDTH-1:0]} >> 1);
            mplr_d = mplr_q >> 1;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            hi_d    = w_prod[2*WIDTH-1:WIDTH];
            lo_d    = w_prod[WIDTH-1:0];
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mul_unit: vector table + scoreboard bench for mul_unit.            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   mul_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ehi;
      logic [31:0] elo;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_done  = 0;
   logic [63:0] sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      if (sgn) begin
         sx = {{32{x[31]}}, x};
         sy = {{32{y[31]}}, y};
         return sx * sy;
      end
      return {32'h0, x} * {32'h0, y};
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      if (rst && done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            check("result", {hi, lo}, sb.pop_front());
         end
      end
   end

   // Drives one request; returns after E0 with start already released.
   task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y, input logic [63:0] exp);
      @(negedge clk);
      is_signed = sgn; a = x; b = y; start = 1'b1;
      sb.push_back(exp);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts edges after E0 until done is seen; 0 means it never came.
   task automatic wait_done(output int edge_n);
      edge_n = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edge_n = e;
            break;
         end
      end
   endtask

   vec_t vecs[8];

   initial begin
      int e_done;
      int first_d, second_d, done_before;

      vecs[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1};
      vecs[3] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[4] = '{1'b1, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 32'h00000000};
      vecs[5] = '{1'b1, 32'h00000007, 32'hFFFFFFF7, 32'hFFFFFFFF, 32'hFFFFFFC1};
      vecs[6] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[7] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

      // Reset is asserted from time zero, with no clock edge needed.
      #1;
      check("reset_outputs", {28'h0, busy, done, 34'h0} | {hi, lo}, 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Latency, pulse width and busy on the first vector.
      issue(vecs[0].sgn, vecs[0].a, vecs[0].b, {vecs[0].ehi, vecs[0].elo});
      check("busy_after_E0", {63'h0, busy}, 64'd1);
      wait_done(e_done);
      check("done_edge", 64'(e_done), 64'd33);
      @(posedge clk); #1;
      check("done_one_cycle", {63'h0, done}, 64'd0);
      check("busy_after_E34", {63'h0, busy}, 64'd0);

      for (int i = 1; i < 8; i++) begin
         issue(vecs[i].sgn, vecs[i].a, vecs[i].b, {vecs[i].ehi, vecs[i].elo});
         wait_done(e_done);
         check("vec_done_edge", 64'(e_done), 64'd33);
         @(posedge clk);
      end

      for (int i = 0; i < 6; i++) begin
         logic        s;
         logic [31:0] x, y;
         s = 1'($urandom_range(0, 1));
         x = $urandom;
         y = $urandom;
         issue(s, x, y, model(s, x, y));
         wait_done(e_done);
         check("rand_done_edge", 64'(e_done), 64'd33);
         @(posedge clk);
      end
      check("scoreboard_empty", 64'(sb.size()), 64'd0);

      // Handshake: start held high, operands change while busy.
      @(negedge clk);
      is_signed = 1'b0; a = 32'd2; b = 32'd3; start = 1'b1;
      sb.push_back(64'h6);
      @(posedge clk);
      first_d = 0; second_d = 0;
      for (int e = 1; e <= 75; e++) begin
         @(posedge clk);
         #1;
         if (e == 1) begin
            a = 32'd4; b = 32'd5;
            sb.push_back(64'h14);
         end
         if (done && first_d == 0) first_d = e;
         else if (done && second_d == 0) second_d = e;
         if (e == 33) check("hs_busy_in_done", {63'h0, busy}, 64'd1);
         if (e == 34) check("hs_idle_after_done", {63'h0, busy}, 64'd0);
         if (e == 40 || e == 67) check("hs_hold_prev", {hi, lo}, 64'h6);
      end
      start = 1'b0;
      check("hs_first_done", 64'(first_d), 64'd33);
      check("hs_second_done", 64'(second_d), 64'd68);
      repeat (3) @(posedge clk);

      // Reset in the middle of RUN aborts without a done.
      issue(1'b0, 32'd7, 32'd9, 64'd63);
      repeat (10) @(posedge clk);
      #2 rst = 1'b0;
      sb.delete();
      #1;
      check("abort_outputs", {28'h0, busy, done, 34'h0} | {hi, lo}, 64'h0);
      done_before = n_done;
      @(negedge clk);
      rst = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      check("abort_no_done", 64'(n_done), 64'(done_before));
      check("abort_idle", {63'h0, busy}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
`default_nettype wire
